// File: rtl/spin_sampler_pkg.sv
// Shared encodings for the spin sampler: FSM states, register field offsets,
// and the decoded form of a configuration write.
package spin_sampler_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_STORE  = 2'd3;

    // rdata field offsets
    localparam int RD_BUSY     = 31;
    localparam int RD_EMPTY    = 30;
    localparam int RD_FULL     = 29;
    localparam int RD_OVF      = 28;
    localparam int RD_ABT      = 27;
    localparam int RD_LVL_LSB  = 16;
    localparam int RD_HEAD_LSB = 0;

    // wdata field offsets
    localparam int WD_START    = 31;
    localparam int WD_NWIN_LSB = 16;
    localparam int WD_LEN_LSB  = 0;

    typedef struct packed {
        logic        start;
        logic [7:0]  n_windows;
        logic [15:0] window_len;
    } cfg_t;

    // Split a configuration write into its fields
    function automatic cfg_t decode_wdata(input logic [31:0] w);
        cfg_t c;
        c.start      = w[WD_START];
        c.n_windows  = w[WD_NWIN_LSB +: 8];
        c.window_len = w[WD_LEN_LSB +: 16];
        return c;
    endfunction

endpackage

// File: rtl/spin_sampler_fifo.sv
// Small synchronous FIFO holding per-window toggle counts. Flush has priority
// over push/pop; a push while full is accepted only if a pop frees a slot.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = count;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push && !(rst || flush)) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spin_sampler.sv
// Samples an asynchronous ring output, counts toggles over programmable
// windows and queues one count per window for readout over the register path.
module spin_sampler
    import spin_sampler_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        axi_rst,
    input  logic        din,
    input  logic        ising_rstn,
    input  logic        wready,
    input  logic        wr_addr_match,
    input  logic [31:0] wdata,
    input  logic        rd_pop,
    output logic [31:0] rdata,
    output logic        busy
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] din_sync;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] rstn_sync;
    logic din_prev;
    logic din_s, run, toggle;

    logic [1:0]       state;
    logic [15:0]      len_q, wcnt;
    logic [7:0]       left_q;
    logic [CNT_W-1:0] tcnt;
    logic             ovf, abt;

    logic             wr, start_ok, push, ovf_set;
    logic             fifo_full, fifo_empty;
    logic [LW-1:0]    fifo_level;
    logic [15:0]      fifo_head;
    cfg_t             cfg;
    logic             unused_wdata;

    assign din_s  = din_sync[SYNC_STAGES-1];
    assign run    = rstn_sync[SYNC_STAGES-1];
    assign toggle = din_s ^ din_prev;

    assign wr       = wready && wr_addr_match;
    assign cfg      = decode_wdata(wdata);
    assign start_ok = cfg.start && (cfg.window_len != '0) && (cfg.n_windows != '0);
    assign unused_wdata = ^wdata[30:24];

    // A store cycle pushes only if the ring is still running and no write
    // is flushing the queue in the same cycle
    assign push    = (state == ST_STORE) && run && !wr;
    assign ovf_set = push && fifo_full && !(rd_pop && !fifo_empty);
    assign busy    = (state != ST_IDLE);

    // Bring din and the anneal enable into the clk domain, plus edge history
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            din_sync  <= '0;
            rstn_sync <= '0;
            din_prev  <= 1'b0;
        end else begin
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            rstn_sync <= {rstn_sync[SYNC_STAGES-2:0], ising_rstn};
            din_prev  <= din_s;
        end
    end

    // Window sequencing, toggle counting and sticky status flags
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            left_q <= '0;
            wcnt   <= '0;
            tcnt   <= '0;
            ovf    <= 1'b0;
            abt    <= 1'b0;
        end else if (wr) begin
            ovf  <= 1'b0;
            abt  <= 1'b0;
            wcnt <= '0;
            tcnt <= '0;
            if (start_ok) begin
                state  <= ST_ARM;
                len_q  <= cfg.window_len;
                left_q <= cfg.n_windows;
            end else begin
                state <= ST_IDLE;
            end
        end else begin
            if (ovf_set) ovf <= 1'b1;
            case (state)
                ST_ARM: begin
                    if (run) begin
                        state <= ST_SAMPLE;
                        wcnt  <= '0;
                        tcnt  <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (!run) begin
                        abt   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        if (toggle && tcnt != CNT_MAX) tcnt <= tcnt + 1'b1;
                        if (wcnt == len_q - 16'd1) state <= ST_STORE;
                        else                       wcnt  <= wcnt + 16'd1;
                    end
                end
                ST_STORE: begin
                    if (!run) begin
                        abt   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tcnt   <= '0;
                        wcnt   <= '0;
                        left_q <= left_q - 8'd1;
                        state  <= (left_q == 8'd1) ? ST_IDLE : ST_SAMPLE;
                    end
                end
                default: ;
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16),
        .LW    (LW)
    ) u_fifo (
        .clk       (clk),
        .rst       (axi_rst),
        .flush     (wr),
        .push      (push),
        .push_data (16'(tcnt)),
        .pop       (rd_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (fifo_head)
    );

    // Status / head word assembled from registered state
    always_comb begin
        rdata = '0;
        rdata[RD_BUSY]               = busy;
        rdata[RD_EMPTY]              = fifo_empty;
        rdata[RD_FULL]               = fifo_full;
        rdata[RD_OVF]                = ovf;
        rdata[RD_ABT]                = abt;
        rdata[RD_LVL_LSB +: 8]       = 8'(fifo_level);
        rdata[RD_HEAD_LSB +: 16]     = fifo_head;
    end

endmodule

// File: tb/tb_spin_sampler.sv
// Bench for spin_sampler: a behavioural window/queue model checked against two
// DUT instances (full-width counter and a narrow saturating one) every cycle,
// plus directed scenarios with literal expected status words.
module tb_spin_sampler;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        axi_rst, din, ising_rstn, wready, wr_addr_match, rd_pop;
    logic [31:0] wdata;
    logic [31:0] rdata, rdata_s;
    logic        busy, busy_s;

    always #5 clk = ~clk;

    spin_sampler #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .axi_rst(axi_rst), .din(din), .ising_rstn(ising_rstn),
        .wready(wready), .wr_addr_match(wr_addr_match), .wdata(wdata),
        .rd_pop(rd_pop), .rdata(rdata), .busy(busy));

    spin_sampler #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .axi_rst(axi_rst), .din(din), .ising_rstn(ising_rstn),
        .wready(wready), .wr_addr_match(wr_addr_match), .wdata(wdata),
        .rd_pop(rd_pop), .rdata(rdata_s), .busy(busy_s));

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int din_mode = 0;
    int din_cnt  = 0;

    // ---------------- behavioural model ----------------
    bit din_h[$], rstn_h[$];
    int mq[$];
    bit m_armed, m_active, m_ovf, m_abt;
    int m_len, m_left, m_pos, m_cnt;

    task automatic model_reset();
        din_h = {}; rstn_h = {}; mq = {};
        for (int i = 0; i < SYNC + 2; i++) begin
            din_h.push_back(1'b0);
            rstn_h.push_back(1'b0);
        end
        m_armed = 0; m_active = 0; m_ovf = 0; m_abt = 0;
        m_len = 0; m_left = 0; m_pos = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit en, tog, pop_ok, push;
        int pv;
        if (axi_rst) begin
            model_reset();
            return;
        end
        din_h.push_front(din);       void'(din_h.pop_back());
        rstn_h.push_front(ising_rstn); void'(rstn_h.pop_back());
        en  = rstn_h[SYNC];
        tog = din_h[SYNC] != din_h[SYNC+1];
        if (wready && wr_addr_match) begin
            mq = {};
            m_ovf = 0; m_abt = 0; m_active = 0;
            m_armed = wdata[31] && (wdata[15:0] != 0) && (wdata[23:16] != 0);
            if (m_armed) begin
                m_len  = int'(wdata[15:0]);
                m_left = int'(wdata[23:16]);
            end
            return;
        end
        push = 0; pv = 0;
        pop_ok = rd_pop && (mq.size() > 0);
        if (m_armed) begin
            if (en) begin
                m_armed = 0; m_active = 1; m_pos = 0; m_cnt = 0;
            end
        end else if (m_active) begin
            if (!en) begin
                m_active = 0; m_abt = 1;
            end else if (m_pos < m_len) begin
                if (tog) m_cnt++;
                m_pos++;
            end else begin
                push = 1; pv = m_cnt;
                m_cnt = 0; m_pos = 0; m_left--;
                if (m_left == 0) m_active = 0;
            end
        end
        if (pop_ok) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(pv);
            else                   m_ovf = 1;
        end
    endtask

    function automatic logic [31:0] expected(input int cap);
        int lvl, hd;
        logic [31:0] r;
        lvl = mq.size();
        hd  = (lvl > 0) ? mq[0] : 0;
        if (hd > cap) hd = cap;
        r = 32'h0;
        r[31] = m_armed || m_active;
        r[30] = (lvl == 0);
        r[29] = (lvl == DEPTH);
        r[28] = m_ovf;
        r[27] = m_abt;
        r[23:16] = 8'(lvl);
        r[15:0]  = 16'(hd);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("rdata_model", rdata, expected(65535));
            check("rdata_sat_model", rdata_s, expected(15));
            check("busy_model", {31'b0, busy}, {31'b0, m_armed || m_active});
        end
    end

    // din pattern generator
    initial forever begin
        @(posedge clk);
        #1;
        if (din_mode == 1) begin
            din_cnt++;
            if (din_cnt == 4) begin din = ~din; din_cnt = 0; end
        end else if (din_mode == 2) begin
            din = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] w);
        wready = 1; wr_addr_match = 1; wdata = w;
        tick();
        wready = 0; wr_addr_match = 0; wdata = 32'h0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    task automatic wait_level(input string name, input int lvl, input int budget);
        int n = 0;
        while (int'(rdata[23:16]) != lvl && n < budget) begin tick(); n++; end
        checks++;
        if (int'(rdata[23:16]) != lvl) begin
            errors++;
            $display("FAIL %s: level %0d expected %0d within %0d cycles", name, rdata[23:16], lvl, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_rst = 1; din = 0; ising_rstn = 0; wready = 0; wr_addr_match = 0;
        wdata = 32'h0; rd_pop = 0;
        repeat (3) tick();
        axi_rst = 0;
        chk_en = 1;

        // Reset state
        check("reset_rdata", rdata, 32'h4000_0000);
        check("reset_busy", {31'b0, busy}, 32'h0);

        // 1: din toggles every 4 clk, 3 windows of 64 -> three counts of 16
        ising_rstn = 1; din_mode = 1;
        repeat (5) tick();
        do_write(32'h8003_0040);
        wait_idle("t1_idle", 1000);
        check("t1_status", rdata, 32'h0003_0010);
        check("t1_sat_status", rdata_s, 32'h0003_000F);
        rd_pop = 1; repeat (3) tick(); rd_pop = 0;
        check("t1_drained", rdata, 32'h4000_0000);

        // 2: static din, one window of 10 -> single count 0
        din_mode = 0;
        repeat (6) tick();
        do_write(32'h8001_000A);
        wait_idle("t2_idle", 200);
        check("t2_status", rdata, 32'h0001_0000);
        rd_pop = 1; tick(); rd_pop = 0;
        check("t2_popped", rdata, 32'h4000_0000);

        // 3: six windows into a 4-deep queue with no pops -> overflow
        din_mode = 1;
        do_write(32'h8006_0008);
        wait_idle("t3_idle", 500);
        check("t3_overflow", rdata, 32'h3004_0002);
        do_write(32'h0000_0000);
        check("t3_cleared", rdata, 32'h4000_0000);

        // 4: enable low holds ARM; dropping it mid-window aborts, keeps entries
        ising_rstn = 0;
        repeat (5) tick();
        do_write(32'h8002_0020);
        repeat (10) tick();
        check("t4_armed", rdata, 32'hC000_0000);
        ising_rstn = 1;
        wait_level("t4_first", 1, 200);
        repeat (5) tick();
        ising_rstn = 0;
        repeat (6) tick();
        check("t4_aborted", rdata, 32'h0801_0008);
        ising_rstn = 1;
        repeat (4) tick();

        // 5: push and pop coincide on a full queue -> level holds, no overflow
        do_write(32'h8005_0008);
        wait_level("t5_full", 4, 300);
        repeat (8) tick();
        rd_pop = 1; tick(); rd_pop = 0;
        wait_idle("t5_idle", 100);
        check("t5_status", rdata, 32'h2004_0002);

        // 6: degenerate starts stay idle; reset mid-window clears everything
        do_write(32'h8001_0000);
        repeat (3) tick();
        check("t6_len0", rdata, 32'h4000_0000);
        do_write(32'h8000_0010);
        repeat (3) tick();
        check("t6_n0", rdata, 32'h4000_0000);
        do_write(32'h8001_0100);
        repeat (20) tick();
        check("t6_running", {31'b0, busy}, 32'h1);
        axi_rst = 1; tick(); axi_rst = 0;
        check("t6_reset", rdata, 32'h4000_0000);

        // Randomised traffic against the model
        din_mode = 2;
        ising_rstn = 1;
        for (int c = 0; c < 5000; c++) begin
            rd_pop        = ($urandom_range(0, 3) == 0);
            wready        = ($urandom_range(0, 39) == 0);
            wr_addr_match = ($urandom_range(0, 2) == 0);
            wdata         = {($urandom_range(0, 7) != 0), 7'($urandom),
                             8'($urandom_range(0, 6)), 16'($urandom_range(0, 40))};
            if ($urandom_range(0, 299) == 0) ising_rstn = ~ising_rstn;
            axi_rst       = ($urandom_range(0, 1999) == 0);
            tick();
        end
        axi_rst = 0; wready = 0; wr_addr_match = 0; rd_pop = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
